// File: rtl/i2s_transmitter_if.sv
// AXI-Stream sample channel feeding the I2S transmitter.
// The master drives beats and the transmitter (slave) returns TREADY.
interface i2s_transmitter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  S_AXIS_TVALID;
    logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                  S_AXIS_TLAST;
    logic                  S_AXIS_TREADY;

    modport master (
        output S_AXIS_TVALID,
        output S_AXIS_TDATA,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TVALID,
        input  S_AXIS_TDATA,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: buffers one stereo pair from AXI-Stream and serialises it MSB first,
// sending silence and pulsing underrun when no pair is pending at a frame boundary.
module i2s_transmitter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SCK_DIV    = 4
) (
    input  logic                S_AXIS_ACLK,
    input  logic                S_AXIS_ARESET,
    i2s_transmitter_if.slave    s_axis,
    output logic                sck,
    output logic                ws,
    output logic                sd,
    output logic                underrun,
    output logic                misalign
);
    localparam int unsigned CNT_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned SLOT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DATA_WIDTH - 1);

    typedef enum logic {StExpectL, StExpectR} in_state_e;

    logic [CNT_W-1:0]      r_cnt,    w_cnt_next;
    logic                  r_sck,    w_sck_next;
    logic                  r_ws,     w_ws_next;
    logic                  r_sd,     w_sd_next;
    logic [SLOT_W-1:0]     r_slot,   w_slot_next;
    logic                  r_ch,     w_ch_next;
    logic [DATA_WIDTH-1:0] r_sh_l,   w_sh_l_next;
    logic [DATA_WIDTH-1:0] r_sh_r,   w_sh_r_next;
    logic [DATA_WIDTH-1:0] r_pend_l, w_pend_l_next;
    logic [DATA_WIDTH-1:0] r_pend_r, w_pend_r_next;
    logic                  r_pend_full, w_pend_full_next;
    in_state_e             r_state,  w_state_next;
    logic                  r_tready, w_tready_next;
    logic                  r_underrun, w_underrun_next;
    logic                  r_misalign, w_misalign_next;

    logic                  w_tc;
    logic                  w_fall;
    logic                  w_hs;
    logic [SLOT_W-1:0]     w_bit_idx;
    logic                  w_bit;

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_cnt       <= '0;
            r_sck       <= 1'b0;
            r_ws        <= 1'b1;
            r_sd        <= 1'b0;
            r_slot      <= SLOT_LAST;
            r_ch        <= 1'b1;
            r_sh_l      <= '0;
            r_sh_r      <= '0;
            r_pend_l    <= '0;
            r_pend_r    <= '0;
            r_pend_full <= 1'b0;
            r_state     <= StExpectL;
            r_tready    <= 1'b0;
            r_underrun  <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_sck       <= w_sck_next;
            r_ws        <= w_ws_next;
            r_sd        <= w_sd_next;
            r_slot      <= w_slot_next;
            r_ch        <= w_ch_next;
            r_sh_l      <= w_sh_l_next;
            r_sh_r      <= w_sh_r_next;
            r_pend_l    <= w_pend_l_next;
            r_pend_r    <= w_pend_r_next;
            r_pend_full <= w_pend_full_next;
            r_state     <= w_state_next;
            r_tready    <= w_tready_next;
            r_underrun  <= w_underrun_next;
            r_misalign  <= w_misalign_next;
        end
    end

    always_comb begin
        w_cnt_next       = r_cnt;
        w_sck_next       = r_sck;
        w_ws_next        = r_ws;
        w_sd_next        = r_sd;
        w_slot_next      = r_slot;
        w_ch_next        = r_ch;
        w_sh_l_next      = r_sh_l;
        w_sh_r_next      = r_sh_r;
        w_pend_l_next    = r_pend_l;
        w_pend_r_next    = r_pend_r;
        w_pend_full_next = r_pend_full;
        w_state_next     = r_state;
        w_underrun_next  = 1'b0;
        w_misalign_next  = 1'b0;

        w_tc      = (r_cnt == CNT_LAST);
        w_fall    = w_tc && r_sck;
        w_hs      = s_axis.S_AXIS_TVALID && r_tready;
        w_bit_idx = SLOT_LAST - r_slot;
        w_bit     = r_ch ? r_sh_r[w_bit_idx] : r_sh_l[w_bit_idx];

        if (w_tc) begin
            w_cnt_next = '0;
            w_sck_next = ~r_sck;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end

        if (w_fall) begin
            w_sd_next = w_bit;
            w_ws_next = (r_slot == SLOT_LAST) ? ~r_ch : r_ch;
            if (r_slot == SLOT_LAST) begin
                w_slot_next = '0;
                w_ch_next   = ~r_ch;
                // Frame boundary: the load sees only a pair completed in an earlier cycle.
                if (r_ch) begin
                    if (r_pend_full) begin
                        w_sh_l_next      = r_pend_l;
                        w_sh_r_next      = r_pend_r;
                        w_pend_full_next = 1'b0;
                    end else begin
                        w_sh_l_next     = '0;
                        w_sh_r_next     = '0;
                        w_underrun_next = 1'b1;
                    end
                end
            end else begin
                w_slot_next = r_slot + SLOT_W'(1);
            end
        end

        // TREADY implies pending is empty, so this never collides with the load above.
        if (w_hs) begin
            case (r_state)
                StExpectL: begin
                    if (s_axis.S_AXIS_TLAST) begin
                        w_misalign_next = 1'b1;
                    end else begin
                        w_pend_l_next = s_axis.S_AXIS_TDATA;
                        w_state_next  = StExpectR;
                    end
                end
                StExpectR: begin
                    if (s_axis.S_AXIS_TLAST) begin
                        w_pend_r_next    = s_axis.S_AXIS_TDATA;
                        w_pend_full_next = 1'b1;
                        w_state_next     = StExpectL;
                    end else begin
                        w_pend_l_next = s_axis.S_AXIS_TDATA;
                    end
                end
                default: w_state_next = StExpectL;
            endcase
        end

        w_tready_next = ~w_pend_full_next;
    end

    assign s_axis.S_AXIS_TREADY = r_tready;
    assign sck      = r_sck;
    assign ws       = r_ws;
    assign sd       = r_sd;
    assign underrun = r_underrun;
    assign misalign = r_misalign;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: a bit-level I2S receiver model rebuilds frames from sck/ws/sd and
// a scoreboard of sent pairs checks them in order.
module tb_i2s_transmitter;
    localparam int unsigned DW        = 32;
    localparam int unsigned SCK_DIV   = 2;
    localparam int unsigned FRAME_CYC = 2 * DW * 2 * SCK_DIV;
    localparam int unsigned BUDGET    = 4 * FRAME_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck, ws, sd, underrun, misalign;

    i2s_transmitter_if #(.DATA_WIDTH(DW)) axis ();

    i2s_transmitter #(
        .DATA_WIDTH(DW),
        .SCK_DIV   (SCK_DIV)
    ) dut (
        .S_AXIS_ACLK  (clk),
        .S_AXIS_ARESET(rst),
        .s_axis       (axis),
        .sck          (sck),
        .ws           (ws),
        .sd           (sd),
        .underrun     (underrun),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_underrun = 0;
    int cnt_misalign = 0;
    logic [2*DW-1:0] q_exp[$];
    logic [2*DW-1:0] q_got[$];

    logic [DW-1:0] mon_sh = '0;
    logic [DW-1:0] mon_l = '0;
    int            mon_bits = 0;
    logic          mon_prev_ws = 1'b1;
    logic          mon_l_ok = 1'b0;

    always @(negedge clk) begin
        if (underrun === 1'b1) cnt_underrun <= cnt_underrun + 1;
        if (misalign === 1'b1) cnt_misalign <= cnt_misalign + 1;
    end

    // Receiver model: sample on sck rise; a ws change marks the LSB of the finished word.
    always @(posedge sck or posedge rst) begin
        if (rst) begin
            mon_bits    <= 0;
            mon_prev_ws <= 1'b1;
            mon_l_ok    <= 1'b0;
        end else begin
            mon_sh <= {mon_sh[DW-2:0], sd};
            if (ws !== mon_prev_ws) begin
                if (mon_bits == DW - 1) begin
                    if (mon_prev_ws == 1'b0) begin
                        mon_l    <= {mon_sh[DW-2:0], sd};
                        mon_l_ok <= 1'b1;
                    end else begin
                        if (mon_l_ok) q_got.push_back({mon_l, mon_sh[DW-2:0], sd});
                        mon_l_ok <= 1'b0;
                    end
                end else begin
                    mon_l_ok <= 1'b0;
                end
                mon_bits <= 0;
            end else begin
                mon_bits <= mon_bits + 1;
            end
            mon_prev_ws <= ws;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last, output bit ok);
        axis.S_AXIS_TVALID = 1'b1;
        axis.S_AXIS_TDATA  = d;
        axis.S_AXIS_TLAST  = last;
        ok = 1'b0;
        for (int k = 0; k < BUDGET && !ok; k++) begin
            if (axis.S_AXIS_TREADY === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, output bit ok);
        bit ok_l, ok_r;
        send_beat(l, 1'b0, ok_l);
        send_beat(r, 1'b1, ok_r);
        ok = ok_l && ok_r;
        if (ok) q_exp.push_back({l, r});
    endtask

    task automatic idle();
        axis.S_AXIS_TVALID = 1'b0;
    endtask

    // Next non-silent frame from the receiver model; silent frames are skipped.
    task automatic get_frame(output logic [2*DW-1:0] f, output bit ok);
        logic [2*DW-1:0] g;
        ok = 1'b0;
        f  = '0;
        for (int k = 0; k < BUDGET && !ok; k++) begin
            while (q_got.size() > 0 && !ok) begin
                g = q_got.pop_front();
                if (g != '0) begin
                    f  = g;
                    ok = 1'b1;
                end
            end
            if (!ok) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        string       names[6] = '{"sck", "ws", "sd", "tready", "underrun", "misalign"};
        logic [5:0]  got;
        logic [5:0]  exp_v;
        exp_v = 6'b010000;
        idle();
        axis.S_AXIS_TDATA = '0;
        axis.S_AXIS_TLAST = 1'b0;
        repeat (3) @(negedge clk);
        got = {sck, ws, sd, axis.S_AXIS_TREADY, underrun, misalign};
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got[5-i] !== exp_v[5-i]) begin
                n_fail++;
                $display("FAIL reset_%s: got %b expected %b", names[i], got[5-i], exp_v[5-i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (axis.S_AXIS_TREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready_rise: got %b expected 1", axis.S_AXIS_TREADY);
        end
    endtask

    task automatic test_single_pair();
        bit ok, ok_f;
        int u0;
        logic [2*DW-1:0] f, e;
        send_pair(32'hA5A5_0001, 32'h8000_0000, ok);
        idle();
        u0 = cnt_underrun;
        get_frame(f, ok_f);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
        n_tests++;
        if (!ok || !ok_f || f !== e) begin
            n_fail++;
            $display("FAIL single_pair: got %h expected %h (sent %0d recv %0d)", f, e, ok, ok_f);
        end
        // Only the boundary that ends this frame may report underrun.
        n_tests++;
        if (cnt_underrun - u0 != 1) begin
            n_fail++;
            $display("FAIL single_pair_underrun: got %0d expected 1", cnt_underrun - u0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] lv[3] = '{32'h1234_5678, 32'h0F0F_F0F0, 32'h7654_3210};
        logic [DW-1:0] rv[3] = '{32'h8765_4321, 32'hF0F0_0F0F, 32'h0123_4567};
        bit ok, rose, ok_f;
        logic pw;
        logic [2*DW-1:0] f, e;
        send_pair(lv[0], rv[0], ok);
        n_tests++;
        if (!ok || axis.S_AXIS_TREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tready_drop: got %b expected 0 (sent %0d)", axis.S_AXIS_TREADY, ok);
        end
        for (int p = 1; p < 3; p++) begin
            rose = 1'b0;
            pw   = ws;
            for (int k = 0; k < BUDGET && !rose; k++) begin
                if (axis.S_AXIS_TREADY === 1'b1) rose = 1'b1;
                else begin
                    pw = ws;
                    @(negedge clk);
                end
            end
            n_tests++;
            if (!rose || pw !== 1'b1 || ws !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_tready_rise%0d: got rose=%0d ws %b->%b expected rose=1 ws 1->0",
                         p, rose, pw, ws);
            end
            send_pair(lv[p], rv[p], ok);
        end
        idle();
        for (int p = 0; p < 3; p++) begin
            get_frame(f, ok_f);
            e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
            n_tests++;
            if (!ok_f || f !== e) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got %h expected %h", p, f, e);
            end
        end
    endtask

    task automatic test_misalign();
        bit ok0, ok1, ok2, ok3, ok_f;
        int m0;
        logic [2*DW-1:0] f, e;
        m0 = cnt_misalign;
        send_beat(32'hDEAD_BEEF, 1'b1, ok0);
        send_beat(32'h1111_1111, 1'b0, ok1);
        send_beat(32'h2222_2222, 1'b0, ok2);
        send_beat(32'h3333_3333, 1'b1, ok3);
        idle();
        if (ok0 && ok1 && ok2 && ok3) q_exp.push_back({32'h2222_2222, 32'h3333_3333});
        get_frame(f, ok_f);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
        n_tests++;
        if (!ok_f || f !== e) begin
            n_fail++;
            $display("FAIL misalign_frame: got %h expected %h", f, e);
        end
        n_tests++;
        if (cnt_misalign - m0 != 1) begin
            n_fail++;
            $display("FAIL misalign_count: got %0d expected 1", cnt_misalign - m0);
        end
    endtask

    task automatic test_loopback();
        bit ok, ok_f;
        logic [DW-1:0] l;
        logic [2*DW-1:0] f, e;
        for (int i = 0; i < 16; i++) begin
            l = (DW'(i) << 24) | DW'(i * 3 + 1);
            send_pair(l, ~l, ok);
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            get_frame(f, ok_f);
            e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
            n_tests++;
            if (!ok_f || f !== e) begin
                n_fail++;
                $display("FAIL loopback_pair%0d: got %h expected %h", i, f, e);
            end
        end
    endtask

    task automatic test_starvation();
        bit seen_hi, seen_fall, sd_bad, rdy_bad;
        int u;
        seen_hi = 1'b0;
        seen_fall = 1'b0;
        for (int k = 0; k < BUDGET && !seen_fall; k++) begin
            @(negedge clk);
            if (ws === 1'b1) seen_hi = 1'b1;
            else if (seen_hi && ws === 1'b0) seen_fall = 1'b1;
        end
        n_tests++;
        if (!seen_fall) begin
            n_fail++;
            $display("FAIL starve_sync: got no ws fall expected one within %0d cycles", BUDGET);
        end
        u = 0;
        sd_bad = 1'b0;
        rdy_bad = 1'b0;
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
            if (k > 0 && sd !== 1'b0) sd_bad = 1'b1;
            if (axis.S_AXIS_TREADY !== 1'b1) rdy_bad = 1'b1;
            if (underrun === 1'b1) u++;
            @(negedge clk);
        end
        n_tests++;
        if (u != 3) begin
            n_fail++;
            $display("FAIL starve_underrun: got %0d expected 3", u);
        end
        n_tests++;
        if (sd_bad) begin
            n_fail++;
            $display("FAIL starve_sd: got nonzero sd expected 0");
        end
        n_tests++;
        if (rdy_bad) begin
            n_fail++;
            $display("FAIL starve_tready: got low tready expected 1");
        end
    endtask

    task automatic test_reset_mid_frame();
        string       names[6] = '{"sck", "ws", "sd", "tready", "underrun", "misalign"};
        logic [5:0]  got;
        logic [5:0]  exp_v;
        bit ok, ok_h, ok_r, ok_f, loaded;
        logic pw, ps;
        int falls, m0;
        logic [2*DW-1:0] f, e;
        exp_v = 6'b010000;
        send_pair(32'hCAFE_F00D, 32'h0BAD_C0DE, ok);
        idle();
        loaded = 1'b0;
        pw = ws;
        for (int k = 0; k < BUDGET && !loaded; k++) begin
            @(negedge clk);
            if (pw === 1'b1 && ws === 1'b0 && underrun === 1'b0) loaded = 1'b1;
            pw = ws;
        end
        send_beat(32'hBAD0_BAD0, 1'b0, ok_h);
        idle();
        falls = 0;
        ps = sck;
        for (int k = 0; k < BUDGET && falls < 10; k++) begin
            @(negedge clk);
            if (ps === 1'b1 && sck === 1'b0) falls++;
            ps = sck;
        end
        n_tests++;
        if (!ok || !loaded || !ok_h || ws !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got sent=%0d loaded=%0d ws=%b expected 1 1 0",
                     ok, loaded, ws);
        end
        rst = 1'b1;
        #1;
        got = {sck, ws, sd, axis.S_AXIS_TREADY, underrun, misalign};
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got[5-i] !== exp_v[5-i]) begin
                n_fail++;
                $display("FAIL rst_mid_%s: got %b expected %b", names[i], got[5-i], exp_v[5-i]);
            end
        end
        q_exp.delete();
        q_got.delete();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m0 = cnt_misalign;
        // The half-received left must be gone: a lone right beat is now misaligned.
        send_beat(32'h5555_AAAA, 1'b1, ok_r);
        send_pair(32'h1357_9BDF, 32'h2468_ACE0, ok);
        idle();
        get_frame(f, ok_f);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
        n_tests++;
        if (!ok_r || !ok_f || f !== e) begin
            n_fail++;
            $display("FAIL rst_mid_frame: got %h expected %h", f, e);
        end
        n_tests++;
        if (cnt_misalign - m0 != 1) begin
            n_fail++;
            $display("FAIL rst_mid_misalign: got %0d expected 1", cnt_misalign - m0);
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_misalign();
        test_loopback();
        test_starvation();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
